// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl
//
// Sequencer and storage for the machine-mode CSR file. One Zicsr access
// (CSRRW/RS/RC and their immediate forms) is accepted at a time and runs as
// an atomic read-modify-write through IDLE -> READ -> WRITE -> RESP. The old
// CSR value, or zero for an illegal access, is returned over a valid/ready
// response channel. The free-running mcycle and minstret counters live here.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid       request present
//   req_ready       request accepted when high (only in IDLE)
//   req_funct3      Zicsr funct3
//   req_addr        12-bit CSR address
//   req_rs1_idx     rs1 index, or zimm for the immediate forms
//   req_rs1_data    rs1 register value
//   instret_pulse   one instruction retired this cycle
//   rsp_valid       response present
//   rsp_ready       consumer accepts the response
//   rsp_rdata       old CSR value (0 when illegal)
//   rsp_illegal     the access was illegal
module csr_access_ctrl #(
    parameter logic [31:0] HART_ID = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_addr,
    input  logic [4:0]  req_rs1_idx,
    input  logic [31:0] req_rs1_data,
    input  logic        instret_pulse,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal
);

    localparam int DATA_W = 32;

    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t state;

    // Captured request fields and the old value sampled in READ
    logic [2:0]        funct3_p0;
    logic [11:0]       addr_p0;
    logic [4:0]        rs1_idx_p0;
    logic [DATA_W-1:0] rs1_data_p0;
    logic [DATA_W-1:0] old_p1;

    // CSR storage
    logic [DATA_W-1:0] mtvec;
    logic [DATA_W-1:0] mscratch;
    logic [DATA_W-1:0] mepc;
    logic [DATA_W-1:0] mcause;
    logic [DATA_W-1:0] mcycle;
    logic [DATA_W-1:0] minstret;

    logic              addr_known;
    logic [DATA_W-1:0] read_val;
    logic [DATA_W-1:0] operand;
    logic              write_req;
    logic              acc_illegal;
    logic [DATA_W-1:0] new_val;
    logic              wr_en;

    // Read-modify-write combine selected by funct3[1:0]
    function automatic logic [DATA_W-1:0] csr_new_value(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] opnd
    );
        case (op)
            2'b01:   return opnd;
            2'b10:   return old_v | opnd;
            2'b11:   return old_v & ~opnd;
            default: return old_v;
        endcase
    endfunction

    // Read mux; mtvec and mepc always read with bits[1:0] cleared
    always_comb begin
        addr_known = 1'b1;
        read_val   = '0;
        case (addr_p0)
            ADDR_MTVEC:    read_val = {mtvec[DATA_W-1:2], 2'b00};
            ADDR_MSCRATCH: read_val = mscratch;
            ADDR_MEPC:     read_val = {mepc[DATA_W-1:2], 2'b00};
            ADDR_MCAUSE:   read_val = mcause;
            ADDR_MCYCLE:   read_val = mcycle;
            ADDR_MINSTRET: read_val = minstret;
            ADDR_MHARTID:  read_val = HART_ID;
            default:       addr_known = 1'b0;
        endcase
    end

    // Set/clear forms with rs1 (or zimm) of zero never write, which keeps a
    // pure read of a read-only CSR legal.
    always_comb begin
        operand     = funct3_p0[2] ? {27'b0, rs1_idx_p0} : rs1_data_p0;
        write_req   = (funct3_p0[1:0] == 2'b01) || (rs1_idx_p0 != 5'd0);
        acc_illegal = !addr_known || (funct3_p0[1:0] == 2'b00) ||
                      (write_req && (addr_p0[11:10] == 2'b11));
        new_val     = csr_new_value(funct3_p0[1:0], old_p1, operand);
        wr_en       = (state == S_WRITE) && write_req && !acc_illegal;
    end

    // Sequencer with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_illegal <= 1'b0;
            funct3_p0   <= '0;
            addr_p0     <= '0;
            rs1_idx_p0  <= '0;
            rs1_data_p0 <= '0;
            old_p1      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_p0   <= req_funct3;
                        addr_p0     <= req_addr;
                        rs1_idx_p0  <= req_rs1_idx;
                        rs1_data_p0 <= req_rs1_data;
                        req_ready   <= 1'b0;
                        state       <= S_READ;
                    end
                end
                // Accept -> READ: sample the old value
                S_READ: begin
                    old_p1 <= read_val;
                    state  <= S_WRITE;
                end
                // READ -> WRITE: storage updates on this edge, response goes out
                S_WRITE: begin
                    rsp_valid   <= 1'b1;
                    rsp_illegal <= acc_illegal;
                    rsp_rdata   <= acc_illegal ? '0 : old_p1;
                    state       <= S_RESP;
                end
                // WRITE -> RESP: hold until the consumer takes it
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // CSR storage; a write in WRITE takes priority over the counter increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle <= mcycle + 32'd1;
            if (instret_pulse) begin
                minstret <= minstret + 32'd1;
            end
            if (wr_en) begin
                case (addr_p0)
                    ADDR_MTVEC:    mtvec    <= {new_val[DATA_W-1:2], 2'b00};
                    ADDR_MSCRATCH: mscratch <= new_val;
                    ADDR_MEPC:     mepc     <= {new_val[DATA_W-1:2], 2'b00};
                    ADDR_MCAUSE:   mcause   <= new_val;
                    ADDR_MCYCLE:   mcycle   <= new_val;
                    ADDR_MINSTRET: minstret <= new_val;
                    default:       ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Testbench for csr_access_ctrl: table of directed accesses, hand-written
// multi-cycle sequences (counter wrap, response stall, reset mid-access) and
// a randomized phase checked against a behavioural CSR model.
module tb_csr_access_ctrl;

    localparam logic [31:0] HART = 32'hC0DE_0001;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_data;
    logic        instret_pulse;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    csr_access_ctrl #(.HART_ID(HART)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_rs1_idx  (req_rs1_idx),
        .req_rs1_data (req_rs1_data),
        .instret_pulse(instret_pulse),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_illegal  (rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic inst_rand = 1'b0;

    // Elapsed cycles and retired-instruction pulses since the last reset
    logic [31:0] tb_cyc;
    logic [31:0] tb_inst;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_cyc  <= '0;
            tb_inst <= '0;
        end else begin
            tb_cyc <= tb_cyc + 32'd1;
            if (instret_pulse) tb_inst <= tb_inst + 32'd1;
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[20];

    // Behavioural model state
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [31:0] m_cyc_base, m_inst_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (inst_rand) instret_pulse = 1'($urandom_range(0, 1));
    endtask

    // Runs one access starting from a negedge in IDLE and ends at the negedge
    // of the following IDLE cycle. Returns the observed response and the
    // bench counters seen during the READ and RESP cycles.
    task automatic access(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                          input logic [31:0] d, input int stall, input int stall_pulses,
                          output logic [31:0] rd, output logic ill,
                          output logic [31:0] c_rd, output logic [31:0] i_rd,
                          output logic [31:0] c_rs, output logic [31:0] i_rs);
        req_valid    = 1'b1;
        req_funct3   = f3;
        req_addr     = a;
        req_rs1_idx  = idx;
        req_rs1_data = d;
        @(posedge clk);
        tick();
        c_rd = tb_cyc;
        i_rd = tb_inst;
        req_valid    = 1'b0;
        req_funct3   = 3'($urandom);
        req_addr     = 12'($urandom);
        req_rs1_idx  = 5'($urandom);
        req_rs1_data = $urandom;
        check("ready_low_read", 32'(req_ready), 32'd0);
        check("vld_low_read", 32'(rsp_valid), 32'd0);
        tick();
        check("vld_low_write", 32'(rsp_valid), 32'd0);
        tick();
        check("vld_high_resp", 32'(rsp_valid), 32'd1);
        rd   = rsp_rdata;
        ill  = rsp_illegal;
        c_rs = tb_cyc;
        i_rs = tb_inst;
        for (int j = 0; j < stall; j++) begin
            req_valid = 1'b1;
            if (stall_pulses > 0) instret_pulse = (j < stall_pulses);
            tick();
            check("stall_vld", 32'(rsp_valid), 32'd1);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_rdata", rsp_rdata, rd);
            check("stall_ill", 32'(rsp_illegal), 32'(ill));
        end
        if (stall_pulses > 0) instret_pulse = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("vld_after_hs", 32'(rsp_valid), 32'd0);
        check("ready_after_hs", 32'(req_ready), 32'd1);
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a, input logic [31:0] c,
                                               input logic [31:0] i);
        case (a)
            12'h305: return m_mtvec & ~32'h3;
            12'h340: return m_mscratch;
            12'h341: return m_mepc & ~32'h3;
            12'h342: return m_mcause;
            12'hB00: return c - m_cyc_base;
            12'hB02: return i - m_inst_base;
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_impl(input logic [11:0] a);
        return (a == 12'h305) || (a == 12'h340) || (a == 12'h341) || (a == 12'h342) ||
               (a == 12'hB00) || (a == 12'hB02) || (a == 12'hF14);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_mtvec = '0; m_mscratch = '0; m_mepc = '0; m_mcause = '0;
        m_cyc_base = '0; m_inst_base = '0;
    endtask

    logic [31:0] rd, c_rd, i_rd, c_rs, i_rs;
    logic        ill;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rs1_idx = '0; req_rs1_data = '0;
        instret_pulse = 1'b0; rsp_ready = 1'b0;

        vecs[0]  = '{3'b001, 12'h340, 5'd5,  32'hDEADBEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{3'b010, 12'h340, 5'd0,  32'hFFFFFFFF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{3'b010, 12'h340, 5'd0,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[3]  = '{3'b110, 12'h341, 5'h1F, 32'h0,        32'h0000_0000, 1'b0};
        vecs[4]  = '{3'b111, 12'h341, 5'h03, 32'h0,        32'h0000_001C, 1'b0};
        vecs[5]  = '{3'b010, 12'h341, 5'd0,  32'h0,        32'h0000_001C, 1'b0};
        vecs[6]  = '{3'b001, 12'hF14, 5'd1,  32'h5,        32'h0000_0000, 1'b1};
        vecs[7]  = '{3'b010, 12'hF14, 5'd0,  32'h0,        HART,          1'b0};
        vecs[8]  = '{3'b011, 12'hF14, 5'd0,  32'hFFFFFFFF, HART,          1'b0};
        vecs[9]  = '{3'b110, 12'hF14, 5'd1,  32'h0,        32'h0000_0000, 1'b1};
        vecs[10] = '{3'b100, 12'h340, 5'd7,  32'h1,        32'h0000_0000, 1'b1};
        vecs[11] = '{3'b000, 12'h340, 5'd7,  32'h1,        32'h0000_0000, 1'b1};
        vecs[12] = '{3'b001, 12'h7C0, 5'd3,  32'hAA,       32'h0000_0000, 1'b1};
        vecs[13] = '{3'b010, 12'h340, 5'd0,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[14] = '{3'b101, 12'h305, 5'h17, 32'h0,        32'h0000_0000, 1'b0};
        vecs[15] = '{3'b011, 12'h305, 5'd2,  32'h0,        32'h0000_0014, 1'b0};
        vecs[16] = '{3'b001, 12'h342, 5'd0,  32'h8000000B, 32'h0000_0000, 1'b0};
        vecs[17] = '{3'b110, 12'h342, 5'd4,  32'h0,        32'h8000000B, 1'b0};
        vecs[18] = '{3'b010, 12'h342, 5'd0,  32'h0,        32'h8000000F, 1'b0};
        vecs[19] = '{3'b010, 12'h300, 5'd0,  32'h0,        32'h0000_0000, 1'b1};

        // Reset state
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
        tick();
        rst = 1'b0;

        // Directed table
        foreach (vecs[k]) begin
            access(vecs[k].f3, vecs[k].addr, vecs[k].idx, vecs[k].data, k % 3, 0,
                   rd, ill, c_rd, i_rd, c_rs, i_rs);
            check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
            check($sformatf("vec%0d_illegal", k), 32'(ill), 32'(vecs[k].exp_ill));
        end

        // mcycle write then back-to-back reads across the wrap
        access(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFE, 0, 0, rd, ill, c_rd, i_rd, c_rs, i_rs);
        check("mcycle_wr_old", rd, c_rd);
        access(3'b010, 12'hB00, 5'd0, 32'h0, 0, 0, rd, ill, c_rd, i_rd, c_rs, i_rs);
        check("mcycle_wrap_rd1", rd, 32'h0000_0000);
        access(3'b010, 12'hB00, 5'd0, 32'h0, 0, 0, rd, ill, c_rd, i_rd, c_rs, i_rs);
        check("mcycle_wrap_rd2", rd, 32'h0000_0004);

        // minstret: stalled response with three retire pulses in the stall
        access(3'b001, 12'hB02, 5'd1, 32'd100, 0, 0, rd, ill, c_rd, i_rd, c_rs, i_rs);
        check("minstret_wr_old", rd, 32'd0);
        access(3'b010, 12'hB02, 5'd0, 32'h0, 5, 3, rd, ill, c_rd, i_rd, c_rs, i_rs);
        check("minstret_stall_rd", rd, 32'd100);
        access(3'b010, 12'hB02, 5'd0, 32'h0, 0, 0, rd, ill, c_rd, i_rd, c_rs, i_rs);
        check("minstret_plus3", rd, 32'd103);

        // Reset asserted during WRITE of a mcause write
        access(3'b001, 12'h342, 5'd1, 32'h77, 0, 0, rd, ill, c_rd, i_rd, c_rs, i_rs);
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h342;
        req_rs1_idx = 5'd1; req_rs1_data = 32'h55;
        @(posedge clk);
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        tick();
        rst = 1'b0;
        access(3'b010, 12'h342, 5'd0, 32'h0, 0, 0, rd, ill, c_rd, i_rd, c_rs, i_rs);
        check("midrst_mcause", rd, 32'd0);
        check("midrst_mcause_ill", 32'(ill), 32'd0);

        // Randomized accesses against the model
        do_reset();
        inst_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [11:0] alist [10];
            logic [11:0] a;
            logic [2:0]  f3;
            logic [4:0]  idx;
            logic [31:0] d, old, opnd, nv, exp_rd;
            logic        wr, exp_ill;
            alist = '{12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                      12'hB02, 12'hF14, 12'h7C0, 12'h300, 12'hB01};
            a   = alist[$urandom_range(0, 9)];
            f3  = 3'($urandom);
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            d   = $urandom;
            access(f3, a, idx, d, $urandom_range(0, 2), 0, rd, ill, c_rd, i_rd, c_rs, i_rs);
            wr      = (f3[1:0] == 2'b01) || (idx != 5'd0);
            exp_ill = !model_impl(a) || (f3[1:0] == 2'b00) || (wr && a[11:10] == 2'b11);
            old     = model_read(a, c_rd, i_rd);
            exp_rd  = exp_ill ? 32'h0 : old;
            check($sformatf("rand%0d_rdata_a%h_f%0d", n, a, f3), rd, exp_rd);
            check($sformatf("rand%0d_illegal", n), 32'(ill), 32'(exp_ill));
            if (!exp_ill && wr) begin
                opnd = f3[2] ? {27'b0, idx} : d;
                case (f3[1:0])
                    2'b01:   nv = opnd;
                    2'b10:   nv = old | opnd;
                    default: nv = old & ~opnd;
                endcase
                case (a)
                    12'h305: m_mtvec    = nv;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc     = nv;
                    12'h342: m_mcause   = nv;
                    12'hB00: m_cyc_base  = c_rs - nv;
                    12'hB02: m_inst_base = i_rs - nv;
                    default: ;
                endcase
            end
        end
        inst_rand = 1'b0;
        instret_pulse = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
# csr_access_ctrl

Sequencer for the machine-mode CSR file. It accepts one Zicsr instruction at a time: CSRRW/RS/RC and the immediate forms CSRRWI/RSI/RCI. Each access runs as an atomic read-modify-write through a fixed multi-cycle FSM, and the old CSR value is returned over a valid/ready response channel. It sits between the decode stage and writeback and owns the CSR storage, including the free-running mcycle and minstret counters.

## Interface
Parameters:
- HART_ID, 32'h0000_0000, value returned by read-only mhartid (0xF14)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_funct3  in  3  instruction funct3
- req_addr  in  12  CSR address
- req_rs1_idx  in  5  rs1 index, or zimm for immediate forms
- req_rs1_data  in  32  rs1 register value
- instret_pulse  in  1  one instruction retired this cycle
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  old CSR value (0 when illegal)
- rsp_illegal  out  1  access was illegal

## Operation
- FSM states are IDLE, READ, WRITE and RESP.
  - IDLE→READ on req_valid&&req_ready; all req_* fields are captured.
  - READ→WRITE unconditionally.
  - WRITE→RESP unconditionally.
  - RESP→IDLE on rsp_ready.
- Implemented CSRs (others illegal):
  - mtvec 0x305: bits[1:0] read 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342.
  - mcycle 0xB00.
  - minstret 0xB02.
  - mhartid 0xF14: read-only, returns HART_ID.
- Operand selection:
  - funct3[2]=1 gives {27'b0, req_rs1_idx}, zero-extended with no sign extension.
  - funct3[2]=0 gives req_rs1_data.
- funct3[1:0] selects the new value:
  - 01: new = operand.
  - 10: new = old | operand.
  - 11: new = old & ~operand.
  - 00: illegal. This covers funct3 000 and 100.
- Write suppression:
  - RS/RC forms (including immediate) with req_rs1_idx==0 perform no write.
  - RW forms always write.
- An access is illegal if any of the following holds:
  - unimplemented address;
  - illegal funct3;
  - a write would occur to an address with addr[11:10]==2'b11.
- On an illegal access: no CSR changes, rsp_rdata=0, rsp_illegal=1. A read-only address with suppressed write is legal.
- Counters:
  - mcycle increments by 1 every cycle.
  - minstret increments by 1 on each cycle instret_pulse=1.
  - Both wrap 0xFFFF_FFFF→0.
  - A CSR write in WRITE overrides the increment in that same cycle; the written value is stored exactly.
- rsp_rdata is the value sampled in READ. For counters this is the count at the READ-cycle edge.

## Timing
- Reset (async assert) puts the FSM in IDLE with:
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_illegal=0;
  - all CSRs=0.
- Reset release is synchronous to clk.
- Accept edge E0 (req_valid&&req_ready). State is READ after E0; at E1 the old value is latched and the state becomes WRITE.
- At E2 the CSR is updated and the state becomes RESP, with rsp_valid=1 and rsp_rdata/rsp_illegal stable.
- Response handshake:
  - rsp_valid, rsp_rdata and rsp_illegal are held until the edge where rsp_valid&&rsp_ready.
  - The state then goes to IDLE, and req_ready=1 in the next cycle.
- Latency: minimum 3 cycles request-to-response. Throughput: one access per 4 cycles with rsp_ready tied high.
- req_ready=0 in READ, WRITE and RESP. req_valid is ignored there and inputs may change freely.
- Reset mid-operation in READ or WRITE before E2: no CSR write occurs and the response is discarded.
- Counters keep incrementing in every state, including while stalled in RESP.

## Test plan
- Reset, then CSRRW 0x340 with rs1_data=0xDEADBEEF, then CSRRS 0x340 rs1_idx=0 → first rdata=0, second rdata=0xDEADBEEF with mscratch unchanged; rsp_valid 3 cycles after accept.
- CSRRSI 0x341 zimm=0x1F, then CSRRCI 0x341 zimm=0x03, then read → rdata sequence 0, 0x1C, 0x1C (bits[1:0] forced 0).
- CSRRW 0xB00 with data 0xFFFF_FFFE, then read twice with rsp_ready high → second read shows wrap through 0 with exact cycle deltas; a write in the same cycle as an increment stores the written value.
- CSRRW 0xF14 → rsp_illegal=1, rdata=0. CSRRS 0xF14 rs1_idx=0 → legal, rdata=HART_ID. Funct3=100 or address 0x7C0 → illegal with no state change.
- Hold rsp_ready=0 for 5 cycles → response stable, req_ready=0, a new req_valid is not accepted. Pulse instret_pulse 3 times during this → minstret +3.
- Assert rst during WRITE of CSRRW 0x342 → mcause=0, rsp_valid=0, req_ready=1 immediately (async).
